keypad_score_entry: RTL and testbench
=====================================

KEYPAD_SCORE_ENTRY -- requirements
Module: keypad_score_entry

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000: clocks per keypad column step.
REQ-002 SHALL have parameter DEBOUNCE_CNT, default 20000: consecutive stable clocks required to accept a press or a release.
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port KEY_ROW  input  4  keypad rows, active-low, externally pulled up.
REQ-006 SHALL have port KEY_COL  output  4  keypad column drive, one-hot active-low.
REQ-007 SHALL have port score  output  7  last accepted score, binary 0..100.
REQ-008 SHALL have port score_valid  output  1  one-cycle pulse when score is updated.
REQ-009 SHALL have port entry_err  output  1  sticky error flag for rejected entry.
REQ-010 SHALL have port entry_bcd  output  12  digits typed so far, {hundreds, tens, units} BCD, right-aligned, for display echo.

Function
REQ-011 Key map (row r, column c): r0 = 1 2 3 A; r1 = 4 5 6 B; r2 = 7 8 9 C; r3 = * 0 # D; * = clear, # = enter, A-D ignored (no state change besides debounce/release).
REQ-012 FSM states SCAN, DEBOUNCE, ACCEPT, RELEASE.
REQ-013 SCAN: KEY_COL rotates 1110 -> 1101 -> 1011 -> 0111 -> 1110, one step every SCAN_DIV clocks; KEY_ROW is sampled on the last clock of each step; any row low -> lock column, capture row pattern, go DEBOUNCE.
REQ-014 Multiple rows low in one column: lowest row index wins.
REQ-015 DEBOUNCE: column held; KEY_ROW must equal the captured pattern for DEBOUNCE_CNT consecutive clocks -> ACCEPT; any mismatch -> SCAN, resuming at the next column.
REQ-016 ACCEPT: exactly one clock; the key is processed; next state RELEASE.
REQ-017 RELEASE: column held; KEY_ROW = 1111 for DEBOUNCE_CNT consecutive clocks -> SCAN; any low row restarts the count; a held key produces exactly one ACCEPT.
REQ-018 Digit key with fewer than 3 digits: accumulator = accumulator*10 + digit (10-bit), digit shifted into entry_bcd units, digit count +1.
REQ-019 Digit key with 3 digits already held: ignored, entry_err set.
REQ-020 Enter with digit count 0, or accumulator > 100: score unchanged, no pulse, entry_err set, buffer cleared.
REQ-021 Valid enter: score <= accumulator[6:0] and score_valid = 1 for the single clock after ACCEPT; buffer, count, and entry_bcd cleared; entry_err cleared.
REQ-022 Clear key: buffer, count, entry_bcd, and entry_err cleared; score unchanged.
REQ-023 score holds its value between valid enters; score_valid is never high for two consecutive clocks.

Reset
REQ-024 RST asserted, asynchronously: state SCAN, KEY_COL = 1110, scan and debounce counters 0, score = 0, score_valid = 0, entry_err = 0, entry_bcd = 0, accumulator and count 0.
REQ-025 RST during DEBOUNCE, ACCEPT, or RELEASE aborts without processing; a key still held after RST release is detected as a new press and accepted once after full debounce.

Configuration
REQ-026 Macro SCORE_STEP10_EN defined: valid enter additionally requires accumulator % 10 == 0; otherwise it is treated as a rejected entry per REQ-020 (e.g., 55 rejected, 50 accepted).
REQ-027 SCORE_STEP10_EN undefined: any value 0..100 is accepted.

Verification (bench: SCAN_DIV = 2, DEBOUNCE_CNT = 4)
REQ-028 Press 7, 0, # (each held 20 clocks, released 20 clocks) -> score = 70, a single one-cycle score_valid, entry_err = 0, entry_bcd = 0.
REQ-029 Press 1, 0, 0, # -> score = 100; then 1, 0, 1, # -> score remains 100, entry_err = 1, no pulse.
REQ-030 Row 0 low for 2 clocks only (bounce) -> no ACCEPT, entry_bcd unchanged, scan resumes at the next column.
REQ-031 Press 4, 2, 5, 6 -> entry_bcd = 0x425, entry_err = 1; then * -> entry_bcd = 0, entry_err = 0, score unchanged.
REQ-032 Hold 9 for 200 clocks -> exactly one digit accepted (entry_bcd = 0x009); assert RST mid-hold -> all outputs at reset values, held 9 re-accepted once after RST release.
REQ-033 With SCORE_STEP10_EN: 5, 5, # -> rejected, entry_err = 1; 5, 0, # -> score = 50, one pulse.

Source files
------------

// File: rtl/keypad_score_entry.sv
// 4x4 keypad scanner with debounce and a 0..100 score entry buffer.
// Define SCORE_STEP10_EN to accept only scores that are multiples of ten.
module keypad_score_entry #(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 20000
) (
    input  logic        clk,
    input  logic        RST,
    input  logic [3:0]  KEY_ROW,
    output logic [3:0]  KEY_COL,
    output logic [6:0]  score,
    output logic        score_valid,
    output logic        entry_err,
    output logic [11:0] entry_bcd
);

    localparam int SW = $clog2(SCAN_DIV + 1);
    localparam int DW = $clog2(DEBOUNCE_CNT + 1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, ACCEPT, RELEASE} state_t;

    state_t        state;
    logic [SW-1:0] scan_cnt;
    logic [DW-1:0] deb_cnt;
    logic [3:0]    row_cap;
    logic [1:0]    col;
    logic [9:0]    acc;
    logic [1:0]    count;

    logic [1:0] row_idx;
    logic       is_digit;
    logic       is_clear;
    logic       is_enter;
    logic [3:0] digit;
    logic       enter_ok;

    // Lowest-index low row wins when several rows are low together.
    always_comb begin
        row_idx = 2'd3;
        if (!row_cap[2]) row_idx = 2'd2;
        if (!row_cap[1]) row_idx = 2'd1;
        if (!row_cap[0]) row_idx = 2'd0;
    end

    always_comb begin
        is_digit = 1'b0;
        is_clear = 1'b0;
        is_enter = 1'b0;
        digit    = 4'd0;
        if (col != 2'd3) begin
            if (row_idx != 2'd3) begin
                is_digit = 1'b1;
                digit    = {2'b0, row_idx} * 4'd3 + {2'b0, col} + 4'd1;
            end else if (col == 2'd0) begin
                is_clear = 1'b1;
            end else if (col == 2'd1) begin
                is_digit = 1'b1;
            end else begin
                is_enter = 1'b1;
            end
        end
    end

`ifdef SCORE_STEP10_EN
    assign enter_ok = (count != 2'd0) && (acc <= 10'd100)
                      && ((acc % 10'd10) == 10'd0);
`else
    assign enter_ok = (count != 2'd0) && (acc <= 10'd100);
`endif

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state       <= SCAN;
            scan_cnt    <= '0;
            deb_cnt     <= '0;
            row_cap     <= 4'hF;
            col         <= 2'd0;
            KEY_COL     <= 4'b1110;
            acc         <= 10'd0;
            count       <= 2'd0;
            score       <= 7'd0;
            score_valid <= 1'b0;
            entry_err   <= 1'b0;
            entry_bcd   <= 12'd0;
        end else begin
            score_valid <= 1'b0;
            unique case (state)
                SCAN: begin
                    if (scan_cnt == SW'(SCAN_DIV - 1)) begin
                        scan_cnt <= '0;
                        if (KEY_ROW != 4'hF) begin
                            row_cap <= KEY_ROW;
                            deb_cnt <= '0;
                            state   <= DEBOUNCE;
                        end else begin
                            col     <= col + 2'd1;
                            KEY_COL <= {KEY_COL[2:0], KEY_COL[3]};
                        end
                    end else begin
                        scan_cnt <= scan_cnt + SW'(1);
                    end
                end
                DEBOUNCE: begin
                    if (KEY_ROW == row_cap) begin
                        if (deb_cnt == DW'(DEBOUNCE_CNT - 1)) begin
                            deb_cnt <= '0;
                            state   <= ACCEPT;
                        end else begin
                            deb_cnt <= deb_cnt + DW'(1);
                        end
                    end else begin
                        deb_cnt  <= '0;
                        scan_cnt <= '0;
                        col      <= col + 2'd1;
                        KEY_COL  <= {KEY_COL[2:0], KEY_COL[3]};
                        state    <= SCAN;
                    end
                end
                ACCEPT: begin
                    deb_cnt <= '0;
                    state   <= RELEASE;
                    if (is_digit) begin
                        if (count == 2'd3) begin
                            entry_err <= 1'b1;
                        end else begin
                            acc       <= acc * 10'd10 + {6'd0, digit};
                            entry_bcd <= {entry_bcd[7:0], digit};
                            count     <= count + 2'd1;
                        end
                    end else if (is_clear) begin
                        acc       <= 10'd0;
                        count     <= 2'd0;
                        entry_bcd <= 12'd0;
                        entry_err <= 1'b0;
                    end else if (is_enter) begin
                        if (enter_ok) begin
                            score       <= acc[6:0];
                            score_valid <= 1'b1;
                            entry_err   <= 1'b0;
                        end else begin
                            entry_err   <= 1'b1;
                        end
                        acc       <= 10'd0;
                        count     <= 2'd0;
                        entry_bcd <= 12'd0;
                    end
                end
                RELEASE: begin
                    // Any low row restarts the release count.
                    if (KEY_ROW == 4'hF) begin
                        if (deb_cnt == DW'(DEBOUNCE_CNT - 1)) begin
                            deb_cnt  <= '0;
                            scan_cnt <= '0;
                            col      <= col + 2'd1;
                            KEY_COL  <= {KEY_COL[2:0], KEY_COL[3]};
                            state    <= SCAN;
                        end else begin
                            deb_cnt <= deb_cnt + DW'(1);
                        end
                    end else begin
                        deb_cnt <= '0;
                    end
                end
                default: state <= SCAN;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_score_entry.sv
// Directed bench for keypad_score_entry with a behavioural keypad model.
// Build with SCORE_STEP10_EN defined to exercise the multiple-of-ten rule.
module tb_keypad_score_entry;

    logic        clk = 1'b0;
    logic        RST = 1'b1;
    logic [3:0]  key_row;
    logic [3:0]  key_col;
    logic [6:0]  score;
    logic        score_valid;
    logic        entry_err;
    logic [11:0] entry_bcd;

    logic       press_en  = 1'b0;
    logic       bounce    = 1'b0;
    logic [1:0] press_row = 2'd0;
    logic [1:0] press_col = 2'd0;

    int n_checks   = 0;
    int n_fail     = 0;
    int pulse_cnt  = 0;
    int double_cnt = 0;
    logic prev_valid = 1'b0;

    always #5 clk = ~clk;

    keypad_score_entry #(.SCAN_DIV(2), .DEBOUNCE_CNT(4)) dut (
        .clk(clk),
        .RST(RST),
        .KEY_ROW(key_row),
        .KEY_COL(key_col),
        .score(score),
        .score_valid(score_valid),
        .entry_err(entry_err),
        .entry_bcd(entry_bcd)
    );

    // Pressed switch shorts its row to the column when that column is driven low.
    always_comb begin
        key_row = 4'hF;
        if (bounce) key_row[0] = 1'b0;
        if (press_en && !key_col[press_col]) key_row[press_row] = 1'b0;
    end

    always @(negedge clk) begin
        if (score_valid) pulse_cnt++;
        if (score_valid && prev_valid) double_cnt++;
        prev_valid = score_valid;
    end

    task automatic press(input logic [1:0] r, input logic [1:0] c);
        @(negedge clk);
        press_row = r;
        press_col = c;
        press_en  = 1'b1;
        repeat (20) @(negedge clk);
        press_en = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    task automatic press_digit(input int d);
        if (d == 0) press(2'd3, 2'd1);
        else press(2'((d - 1) / 3), 2'((d - 1) % 3));
    endtask

    task automatic test_reset;
        RST = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (key_col !== 4'b1110) begin
            n_fail++;
            $display("FAIL reset_col: got %b expected 1110", key_col);
        end
        n_checks++;
        if (score !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_score: got %0d expected 0", score);
        end
        n_checks++;
        if (score_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid: got %b expected 0", score_valid);
        end
        n_checks++;
        if (entry_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_err: got %b expected 0", entry_err);
        end
        n_checks++;
        if (entry_bcd !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_bcd: got %h expected 000", entry_bcd);
        end
        RST = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_enter_70;
        int p0;
        p0 = pulse_cnt;
        press_digit(7);
        press_digit(0);
        n_checks++;
        if (entry_bcd !== 12'h070) begin
            n_fail++;
            $display("FAIL bcd_70: got %h expected 070", entry_bcd);
        end
        press(2'd3, 2'd2);
        n_checks++;
        if (score !== 7'd70) begin
            n_fail++;
            $display("FAIL score_70: got %0d expected 70", score);
        end
        n_checks++;
        if (pulse_cnt - p0 !== 1) begin
            n_fail++;
            $display("FAIL pulses_70: got %0d expected 1", pulse_cnt - p0);
        end
        n_checks++;
        if (entry_err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_70: got %b expected 0", entry_err);
        end
        n_checks++;
        if (entry_bcd !== 12'h000) begin
            n_fail++;
            $display("FAIL bcd_after_70: got %h expected 000", entry_bcd);
        end
    endtask

    task automatic test_range;
        int p0;
        p0 = pulse_cnt;
        press_digit(1);
        press_digit(0);
        press_digit(0);
        n_checks++;
        if (entry_bcd !== 12'h100) begin
            n_fail++;
            $display("FAIL bcd_100: got %h expected 100", entry_bcd);
        end
        press(2'd3, 2'd2);
        n_checks++;
        if (score !== 7'd100) begin
            n_fail++;
            $display("FAIL score_100: got %0d expected 100", score);
        end
        n_checks++;
        if (pulse_cnt - p0 !== 1) begin
            n_fail++;
            $display("FAIL pulses_100: got %0d expected 1", pulse_cnt - p0);
        end
        p0 = pulse_cnt;
        press_digit(1);
        press_digit(0);
        press_digit(1);
        n_checks++;
        if (entry_bcd !== 12'h101) begin
            n_fail++;
            $display("FAIL bcd_101: got %h expected 101", entry_bcd);
        end
        press(2'd3, 2'd2);
        n_checks++;
        if (score !== 7'd100) begin
            n_fail++;
            $display("FAIL score_101: got %0d expected 100", score);
        end
        n_checks++;
        if (entry_err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_101: got %b expected 1", entry_err);
        end
        n_checks++;
        if (pulse_cnt - p0 !== 0) begin
            n_fail++;
            $display("FAIL pulses_101: got %0d expected 0", pulse_cnt - p0);
        end
        n_checks++;
        if (entry_bcd !== 12'h000) begin
            n_fail++;
            $display("FAIL bcd_after_101: got %h expected 000", entry_bcd);
        end
    endtask

    task automatic test_bounce;
        logic [3:0]  prev;
        logic [3:0]  c;
        logic [11:0] bcd0;
        bit          seen;
        bcd0 = entry_bcd;
        @(negedge clk);
        prev = key_col;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (key_col !== prev) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL scan_timeout: got no column step expected one within 10 clocks");
        end
        c = key_col;
        bounce = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bounce = 1'b0;
        n_checks++;
        if (key_col !== c) begin
            n_fail++;
            $display("FAIL bounce_lock: got %b expected %b", key_col, c);
        end
        @(negedge clk);
        n_checks++;
        if (key_col !== {c[2:0], c[3]}) begin
            n_fail++;
            $display("FAIL bounce_next: got %b expected %b", key_col, {c[2:0], c[3]});
        end
        repeat (20) @(negedge clk);
        n_checks++;
        if (entry_bcd !== bcd0) begin
            n_fail++;
            $display("FAIL bounce_bcd: got %h expected %h", entry_bcd, bcd0);
        end
    endtask

    task automatic test_too_many;
        press(2'd3, 2'd0);
        n_checks++;
        if (entry_err !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_err: got %b expected 0", entry_err);
        end
        press_digit(4);
        press_digit(2);
        press_digit(5);
        n_checks++;
        if (entry_bcd !== 12'h425 || entry_err !== 1'b0) begin
            n_fail++;
            $display("FAIL bcd_425: got %h/%b expected 425/0", entry_bcd, entry_err);
        end
        press_digit(6);
        n_checks++;
        if (entry_bcd !== 12'h425) begin
            n_fail++;
            $display("FAIL bcd_4th: got %h expected 425", entry_bcd);
        end
        n_checks++;
        if (entry_err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_4th: got %b expected 1", entry_err);
        end
        press(2'd3, 2'd0);
        n_checks++;
        if (entry_bcd !== 12'h000 || entry_err !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_all: got %h/%b expected 000/0", entry_bcd, entry_err);
        end
        n_checks++;
        if (score !== 7'd100) begin
            n_fail++;
            $display("FAIL clear_score: got %0d expected 100", score);
        end
    endtask

    task automatic test_hold_reset;
        @(negedge clk);
        press_row = 2'd2;
        press_col = 2'd2;
        press_en  = 1'b1;
        repeat (100) @(negedge clk);
        n_checks++;
        if (entry_bcd !== 12'h009) begin
            n_fail++;
            $display("FAIL hold_bcd: got %h expected 009", entry_bcd);
        end
        #2 RST = 1'b1;
        #1;
        n_checks++;
        if (key_col !== 4'b1110 || score !== 7'd0 || score_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL async_rst: got %b/%0d/%b expected 1110/0/0", key_col, score, score_valid);
        end
        n_checks++;
        if (entry_err !== 1'b0 || entry_bcd !== 12'h000) begin
            n_fail++;
            $display("FAIL async_rst_buf: got %b/%h expected 0/000", entry_err, entry_bcd);
        end
        @(negedge clk);
        @(negedge clk);
        RST = 1'b0;
        repeat (100) @(negedge clk);
        n_checks++;
        if (entry_bcd !== 12'h009) begin
            n_fail++;
            $display("FAIL rehold_bcd: got %h expected 009", entry_bcd);
        end
        press_en = 1'b0;
        repeat (20) @(negedge clk);
        n_checks++;
        if (entry_bcd !== 12'h009) begin
            n_fail++;
            $display("FAIL release_bcd: got %h expected 009", entry_bcd);
        end
    endtask

    task automatic test_step10;
        int p0;
        press(2'd3, 2'd0);
        p0 = pulse_cnt;
        press_digit(5);
        press_digit(5);
        press(2'd3, 2'd2);
`ifdef SCORE_STEP10_EN
        n_checks++;
        if (score !== 7'd0 || entry_err !== 1'b1) begin
            n_fail++;
            $display("FAIL step_55: got %0d/%b expected 0/1", score, entry_err);
        end
        n_checks++;
        if (pulse_cnt - p0 !== 0) begin
            n_fail++;
            $display("FAIL pulses_55: got %0d expected 0", pulse_cnt - p0);
        end
        p0 = pulse_cnt;
        press_digit(5);
        press_digit(0);
        press(2'd3, 2'd2);
        n_checks++;
        if (score !== 7'd50 || entry_err !== 1'b0) begin
            n_fail++;
            $display("FAIL step_50: got %0d/%b expected 50/0", score, entry_err);
        end
        n_checks++;
        if (pulse_cnt - p0 !== 1) begin
            n_fail++;
            $display("FAIL pulses_50: got %0d expected 1", pulse_cnt - p0);
        end
`else
        n_checks++;
        if (score !== 7'd55 || entry_err !== 1'b0) begin
            n_fail++;
            $display("FAIL any_55: got %0d/%b expected 55/0", score, entry_err);
        end
        n_checks++;
        if (pulse_cnt - p0 !== 1) begin
            n_fail++;
            $display("FAIL pulses_55: got %0d expected 1", pulse_cnt - p0);
        end
`endif
    endtask

    initial begin
        test_reset;
        test_enter_70;
        test_range;
        test_bounce;
        test_too_many;
        test_hold_reset;
        test_step10;
        n_checks++;
        if (double_cnt !== 0) begin
            n_fail++;
            $display("FAIL pulse_width: got %0d double pulses expected 0", double_cnt);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
